// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle event pulses into a fixed-length level with optional lockout gap
// Optional retrigger-in-HOLD behaviour: define PULSE_STRETCHER_RETRIGGER_EN.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  output logic en,
  output logic busy,
  output logic drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (a) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (a) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == '0) begin
`else
        drop_d = a;
        if (cnt_q == '0) begin
`endif
          // A zero-length gap skips straight back to IDLE.
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        drop_d = a;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    en   = (state_q == HOLD);
    busy = (state_q != IDLE);
    drop = drop_q;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench for pulse_stretcher (4/2 instance and 1/0 instance)
module tb_pulse_stretcher;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic a0    = 1'b0;
  logic a1    = 1'b0;
  logic en0, busy0, drop0;
  logic en1, busy1, drop1;

  int total = 0;
  int bad   = 0;
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .a(a0), .en(en0), .busy(busy0), .drop(drop0)
  );

  pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .a(a1), .en(en1), .busy(busy1), .drop(drop1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Expected vector per cycle: {en0, busy0, drop0, en1, busy1, drop1}.
  task automatic run(input string name,
                     input logic [31:0] am0, input logic [31:0] am1,
                     input logic [31:0] e_en0, input logic [31:0] e_busy0, input logic [31:0] e_drop0,
                     input logic [31:0] e_en1, input logic [31:0] e_busy1, input logic [31:0] e_drop1,
                     input int rst_cyc);
    logic [5:0] exp;
    reset = 1'b0;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk);
      #1;
      if (c == 4 || c == rst_cyc + 1) reset = 1'b1;
      if (c < 4) begin
        a0 = c[0];
        a1 = ~c[0];
      end else begin
        a0 = am0[c];
        a1 = am1[c];
      end
      sb.push_back({e_en0[c], e_busy0[c], e_drop0[c], e_en1[c], e_busy1[c], e_drop1[c]});
      #1;
      exp = sb.pop_front();
      check_val($sformatf("%s c%0d", name, c),
                {26'd0, en0, busy0, drop0, en1, busy1, drop1}, {26'd0, exp});
      if (c == rst_cyc) begin
        #1 reset = 1'b0;
        #1 check_val($sformatf("%s async_rst", name), {29'd0, en0, busy0, drop0}, 32'd0);
      end
    end
  endtask

  initial begin
    run("single", rng(10, 10), '0, rng(11, 14), rng(11, 16), '0, '0, '0, '0, 100);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    run("hold_pulse", rng(10, 10) | rng(12, 12), '0, rng(11, 16), rng(11, 18), '0, '0, '0, '0, 100);
`else
    run("hold_pulse", rng(10, 10) | rng(12, 12), '0, rng(11, 14), rng(11, 16), rng(13, 13), '0, '0, '0, 100);
`endif
    run("gap_pulse", rng(10, 10) | rng(15, 15) | rng(17, 17), '0,
        rng(11, 14) | rng(18, 21), rng(11, 16) | rng(18, 23), rng(16, 16), '0, '0, '0, 100);
    run("async", rng(10, 10) | rng(15, 15), '0,
        rng(11, 12) | rng(16, 19), rng(11, 12) | rng(16, 21), '0, '0, '0, '0, 12);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    run("held", rng(10, 20), '0, rng(11, 24), rng(11, 26), '0, '0, '0, '0, 100);
    run("h1g0", '0, rng(10, 12), '0, '0, '0, rng(11, 13), rng(11, 13), '0, 100);
`else
    run("held", rng(10, 20), '0, rng(11, 14) | rng(18, 21), rng(11, 16) | rng(18, 23),
        rng(12, 17) | rng(19, 21), '0, '0, '0, 100);
    run("h1g0", '0, rng(10, 12), '0, '0, '0,
        rng(11, 11) | rng(13, 13), rng(11, 11) | rng(13, 13), rng(12, 12), 100);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
